// File: rtl/regfile_param_sb.sv
// Parameterised multi-read register file with a hard-wired zero register, a pending-write
// scoreboard and a full-array scrub FSM; define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_param_sb #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NREAD = 2,
    parameter int unsigned ZREG  = DEPTH - 1,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic [NREAD*AW-1:0]    RA,
    output logic [NREAD*WIDTH-1:0] BusR,
    output logic [NREAD-1:0]       BusyR,
    input  logic [AW-1:0]          RW,
    input  logic [WIDTH-1:0]       BusW,
    input  logic                   RegWr,
    input  logic                   RsvEn,
    input  logic [AW-1:0]          RsvReg,
    input  logic                   ClearReq,
    output logic                   ClearBusy,
    output logic                   ClearDone
);

    localparam logic [AW-1:0] ZIDX = AW'(ZREG);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic wr_acc, rsv_acc, clr_en;

    assign wr_acc  = RegWr && (state_q == StIdle) && (RW != ZIDX);
    assign rsv_acc = RsvEn && (state_q == StIdle) && (RsvReg != ZIDX);
    assign clr_en  = (state_q == StClear);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        // Reserve is applied after the write clear so a same-edge reserve wins.
        if (wr_acc) begin
            busy_d[RW] = 1'b0;
        end
        if (rsv_acc) begin
            busy_d[RsvReg] = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (ClearReq) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_q == LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(negedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            if (wr_acc) begin
                mem_q[RW] <= BusW;
            end
            if (clr_en) begin
                mem_q[cnt_q] <= '0;
            end
        end
    end

    always_comb begin
        BusR  = '0;
        BusyR = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            if (RA[i*AW +: AW] != ZIDX) begin
                BusR[i*WIDTH +: WIDTH] = mem_q[RA[i*AW +: AW]];
                BusyR[i]               = busy_q[RA[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (wr_acc && (RA[i*AW +: AW] == RW)) begin
                    BusR[i*WIDTH +: WIDTH] = BusW;
                    BusyR[i]               = 1'b0;
                end
`endif
            end
        end
    end

    assign ClearBusy = (state_q == StClear);
    assign ClearDone = done_q;

endmodule

// File: tb/tb_regfile_param_sb.sv
// Self-checking bench for regfile_param_sb at default parameters against an array-based model;
// honours REGFILE_BYPASS_EN when defined.
module tb_regfile_param_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         Clk, Resetn;
    logic [9:0]   RA;
    logic [127:0] BusR;
    logic [1:0]   BusyR;
    logic [4:0]   RW;
    logic [63:0]  BusW;
    logic         RegWr, RsvEn;
    logic [4:0]   RsvReg;
    logic         ClearReq, ClearBusy, ClearDone;

    regfile_param_sb dut (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .RA       (RA),
        .BusR     (BusR),
        .BusyR    (BusyR),
        .RW       (RW),
        .BusW     (BusW),
        .RegWr    (RegWr),
        .RsvEn    (RsvEn),
        .RsvReg   (RsvReg),
        .ClearReq (ClearReq),
        .ClearBusy(ClearBusy),
        .ClearDone(ClearDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests  = 0;
    int failed = 0;

    logic [63:0] mem_m  [32];
    bit          busy_m [32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mem_m[i]  = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    // Expected read value given the model and the inputs currently driven (FSM idle).
    function automatic logic [63:0] exp_data(input int a);
        if (a == 31) return 64'h0;
        if (BYP && RegWr && RW != 5'd31 && a == int'(RW)) return BusW;
        return mem_m[a];
    endfunction

    function automatic logic [63:0] exp_busy(input int a);
        if (a == 31) return 64'h0;
        if (BYP && RegWr && RW != 5'd31 && a == int'(RW)) return 64'h0;
        return {63'h0, busy_m[a]};
    endfunction

    task automatic read_check(input string tag, input int a0, input int a1);
        RA = {5'(a1), 5'(a0)};
        #1;
        check({tag, "_d0"}, BusR[63:0], exp_data(a0));
        check({tag, "_d1"}, BusR[127:64], exp_data(a1));
        check({tag, "_b0"}, {63'h0, BusyR[0]}, exp_busy(a0));
        check({tag, "_b1"}, {63'h0, BusyR[1]}, exp_busy(a1));
    endtask

    // One falling edge in idle operation; the model absorbs the inputs seen at that edge.
    task automatic step();
        @(negedge Clk);
        if (RegWr && RW != 5'd31) begin
            mem_m[RW]  = BusW;
            busy_m[RW] = 1'b0;
        end
        if (RsvEn && RsvReg != 5'd31) busy_m[RsvReg] = 1'b1;
        #1;
    endtask

    task automatic do_write(input int a, input logic [63:0] d);
        RegWr = 1'b1;
        RW    = 5'(a);
        BusW  = d;
        step();
        RegWr = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) read_check(tag, a, a + 16);
    endtask

    int busy_cyc, done_cnt;

    initial begin
        RA = '0; RW = '0; BusW = '0; RegWr = 0; RsvEn = 0; RsvReg = '0; ClearReq = 0;
        Resetn = 1'b1;
        #2 Resetn = 1'b0;
        #1;
        model_reset();
        check("rst_clear_busy", {63'h0, ClearBusy}, 64'h0);
        check("rst_clear_done", {63'h0, ClearDone}, 64'h0);
        sweep("rst");
        @(posedge Clk);
        Resetn = 1'b1;
        @(negedge Clk);
        #1;

        // Load k into every register, then the zero register with a non-zero value.
        for (int k = 0; k < 32; k++) do_write(k, 64'(k));
        sweep("load");
        do_write(31, 64'h12345678);
        read_check("zreg", 31, 30);

        // Disabled write must leave X3 untouched.
        RW = 5'd3; BusW = 64'h12345678; RegWr = 1'b0;
        step();
        read_check("nowr", 3, 4);

        // Scoreboard: reserve, write-clears, same-edge reserve+write.
        RsvEn = 1'b1; RsvReg = 5'd5;
        step();
        RsvEn = 1'b0;
        read_check("rsv5", 5, 6);
        check("rsv5_busy", {63'h0, BusyR[0]}, 64'h1);
        do_write(5, 64'hAA);
        read_check("wr5", 5, 5);
        RsvEn = 1'b1; RsvReg = 5'd6;
        do_write(6, 64'h66);
        RsvEn = 1'b0;
        read_check("rsvwr6", 6, 5);
        check("rsvwr6_busy", {63'h0, BusyR[0]}, 64'h1);

        // Forwarding behaviour before the edge, then committed value after.
        RegWr = 1'b1; RW = 5'd7; BusW = 64'h55;
        read_check("byp_pre", 7, 8);
        step();
        RegWr = 1'b0;
        read_check("byp_post", 7, 7);
        check("byp_post_val", BusR[63:0], 64'h55);

        // Randomised idle traffic.
        for (int c = 0; c < 300; c++) begin
            RegWr  = 1'($urandom_range(0, 1));
            RW     = 5'($urandom_range(0, 31));
            BusW   = {$urandom, $urandom};
            RsvEn  = 1'($urandom_range(0, 1));
            RsvReg = 5'($urandom_range(0, 31));
            read_check("rnd", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            step();
        end
        RegWr = 1'b0; RsvEn = 1'b0;
        sweep("rnd_end");

        // Full scrub with a write on the entry edge and one ignored write mid-scrub.
        for (int k = 0; k < 31; k++) do_write(k, 64'(k));
        RsvEn = 1'b1; RsvReg = 5'd4;
        step();
        RsvEn = 1'b0;
        ClearReq = 1'b1; RegWr = 1'b1; RW = 5'd9; BusW = 64'h900D;
        @(negedge Clk);
        #1;
        ClearReq = 1'b0; RegWr = 1'b0;
        mem_m[9] = 64'h900D;
        RA = {5'd10, 5'd9};
        #1;
        check("scrub_entry_wr", BusR[63:0], 64'h900D);
        busy_cyc = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (ClearBusy) busy_cyc++;
            if (ClearDone) done_cnt++;
            if (i == 1) begin
                RA = {5'd10, 5'd0};
                #1;
                check("scrub_x0", BusR[63:0], 64'h0);
                check("scrub_x10", BusR[127:64], 64'd10);
            end
            if (i == 5) begin
                RegWr = 1'b1; RW = 5'd0; BusW = 64'hDEAD;
            end
            if (i == 6) RegWr = 1'b0;
            @(negedge Clk);
            #1;
        end
        check("scrub_busy_cycles", 64'(busy_cyc), 64'd32);
        check("scrub_done_pulses", 64'(done_cnt), 64'd1);
        model_reset();
        sweep("scrub_after");

        // Reset asserted ten edges into a scrub.
        for (int k = 0; k < 31; k++) do_write(k, 64'(k + 100));
        ClearReq = 1'b1;
        @(negedge Clk);
        #1;
        ClearReq = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge Clk);
        #1;
        check("midrst_busy_pre", {63'h0, ClearBusy}, 64'h1);
        Resetn = 1'b0;
        #1;
        model_reset();
        check("midrst_clear_busy", {63'h0, ClearBusy}, 64'h0);
        check("midrst_clear_done", {63'h0, ClearDone}, 64'h0);
        sweep("midrst");
        @(posedge Clk);
        Resetn = 1'b1;
        do_write(1, 64'd77);
        read_check("post_rst_wr", 1, 2);
        check("post_rst_busy", {63'h0, ClearBusy}, 64'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (ClearDone) done_cnt++;
            @(negedge Clk);
            #1;
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
